// File: rtl/rcadder_sweep_checker.sv
// Exhaustive self-test sweep for a WIDTH-bit ripple-carry adder: drives every {a,b,cin},
// waits SETTLE cycles, checks sum/cout against a golden add. Optional: RCADDER_STOP_ON_FAIL_EN.
module rcadder_sweep_checker #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [WIDTH-1:0]   a_out,
   output logic [WIDTH-1:0]   b_out,
   output logic               cin_out,
   input  logic [WIDTH-1:0]   sum_in,
   input  logic               cout_in,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH+1:0] pass_cnt,
   output logic [2*WIDTH+1:0] fail_cnt,
   output logic               first_fail_valid,
   output logic [2*WIDTH:0]   first_fail_vec
);

   localparam int VW         = 2*WIDTH+1;
   localparam int CW         = 2*WIDTH+2;
   localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
   localparam int SCW        = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
   localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_EFF-1);
   localparam logic [VW-1:0]  VEC_LAST    = '1;

   typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

   state_t          state, state_nxt;
   logic [VW-1:0]   vec;
   logic [SCW-1:0]  settle_cnt;
   logic [WIDTH:0]  golden;
   logic            match;
   logic            clr, settle_inc, chk, vec_inc;

   assign {a_out, b_out, cin_out} = vec;
   assign golden = (WIDTH+1)'(a_out) + (WIDTH+1)'(b_out) + (WIDTH+1)'(cin_out);
   assign match  = (golden == {cout_in, sum_in});

   always_comb begin
      state_nxt  = state;
      busy       = 1'b0;
      done       = 1'b0;
      clr        = 1'b0;
      settle_inc = 1'b0;
      chk        = 1'b0;
      vec_inc    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               clr       = 1'b1;
               state_nxt = DRIVE;
            end
         end
         DRIVE: begin
            busy = 1'b1;
            if (settle_cnt == SETTLE_LAST) state_nxt = CHECK;
            else                           settle_inc = 1'b1;
         end
         CHECK: begin
            busy = 1'b1;
            chk  = 1'b1;
            // Last vector stays on the operand outputs while DONE holds.
            if (vec == VEC_LAST) state_nxt = DONE;
`ifdef RCADDER_STOP_ON_FAIL_EN
            else if (!match) state_nxt = DONE;
`endif
            else begin
               vec_inc   = 1'b1;
               state_nxt = DRIVE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               clr       = 1'b1;
               state_nxt = DRIVE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         vec              <= '0;
         settle_cnt       <= '0;
         pass_cnt         <= '0;
         fail_cnt         <= '0;
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
      end else begin
         state <= state_nxt;
         if (clr) begin
            vec              <= '0;
            settle_cnt       <= '0;
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
         end else begin
            if (settle_inc) settle_cnt <= settle_cnt + SCW'(1);
            if (chk) begin
               if (match) pass_cnt <= pass_cnt + CW'(1);
               else begin
                  fail_cnt <= fail_cnt + CW'(1);
                  if (!first_fail_valid) begin
                     first_fail_valid <= 1'b1;
                     first_fail_vec   <= vec;
                  end
               end
            end
            if (vec_inc) begin
               vec        <= vec + VW'(1);
               settle_cnt <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_rcadder_sweep_checker.sv
// Scoreboard bench: a faulty-adder model sits on the DUT's operand ports; each sweep's expected
// totals come from a plain loop over all vectors and are checked when done rises.
module tb_rcadder_sweep_checker;
   localparam int WIDTH      = 4;
   localparam int SETTLE     = 2;
   localparam int VW         = 2*WIDTH+1;
   localparam int NV         = 1 << VW;
   localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
   localparam int MASK       = (1 << WIDTH) - 1;

   logic               clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [WIDTH-1:0]   a_out, b_out, sum_in;
   logic               cin_out, cout_in, busy, done, first_fail_valid;
   logic [2*WIDTH+1:0] pass_cnt, fail_cnt;
   logic [2*WIDTH:0]   first_fail_vec;

   rcadder_sweep_checker #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst), .start(start),
      .a_out(a_out), .b_out(b_out), .cin_out(cin_out),
      .sum_in(sum_in), .cout_in(cout_in),
      .busy(busy), .done(done),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
      .first_fail_valid(first_fail_valid), .first_fail_vec(first_fail_vec)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // fault modes: 0 none, 1 sum bit stuck-0, 2 sum bit stuck-1, 3 cout inverted, 4 one vector wrong
   int fault_mode = 0, fault_bit = 0, fault_vec = 0;

   function automatic logic [WIDTH:0] adder_model(input int v, input int fm, input int fb, input int fv);
      int a, b, c;
      logic [WIDTH:0] r;
      a = (v >> (WIDTH+1)) & MASK;
      b = (v >> 1) & MASK;
      c = v & 1;
      r = (WIDTH+1)'(a + b + c);
      case (fm)
         1: r[fb] = 1'b0;
         2: r[fb] = 1'b1;
         3: r[WIDTH] = ~r[WIDTH];
         4: if (v == fv) r[0] = ~r[0];
         default: ;
      endcase
      return r;
   endfunction

   always_comb {cout_in, sum_in} = adder_model(int'({a_out, b_out, cin_out}), fault_mode, fault_bit, fault_vec);

   typedef struct {
      int pass_n;
      int fail_n;
      int ffv;
      int ffvec;
      int lat;
      int last_vec;
      int start_edge;
   } exp_t;

   exp_t exp_q[$];
   int total = 0, bad = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t sweep_model(input int fm, input int fb, input int fv);
      exp_t e;
      int checked;
      e = '{default: 0};
      checked = 0;
      for (int v = 0; v < NV; v++) begin
         int a, b, c, gold, got;
         a = (v >> (WIDTH+1)) & MASK;
         b = (v >> 1) & MASK;
         c = v & 1;
         gold = a + b + c;
         got = int'(adder_model(v, fm, fb, fv));
         checked++;
         if (got == gold) e.pass_n++;
         else begin
            e.fail_n++;
            if (e.ffv == 0) begin
               e.ffv = 1;
               e.ffvec = v;
            end
`ifdef RCADDER_STOP_ON_FAIL_EN
            break;
`endif
         end
      end
      e.lat = checked * (SETTLE_EFF + 1);
      e.last_vec = checked - 1;
      return e;
   endfunction

   // Monitor: every rising edge of done closes out the oldest outstanding sweep.
   logic done_q = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (done && !done_q) begin
         if (exp_q.size() == 0) check("sb_unexpected_done", 1, 0);
         else begin
            e = exp_q.pop_front();
            check("pass_cnt", int'(pass_cnt), e.pass_n);
            check("fail_cnt", int'(fail_cnt), e.fail_n);
            check("first_fail_valid", int'(first_fail_valid), e.ffv);
            check("first_fail_vec", int'(first_fail_vec), e.ffvec);
            check("done_latency", cyc - e.start_edge, e.lat);
            check("busy_at_done", int'(busy), 0);
            check("held_vector", int'({a_out, b_out, cin_out}), e.last_vec);
         end
      end
      done_q <= done;
   end

   task automatic issue_start();
      exp_t e;
      @(negedge clk);
      e = sweep_model(fault_mode, fault_bit, fault_vec);
      e.start_edge = cyc + 1;
      exp_q.push_back(e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < NV*(SETTLE_EFF+1) + 50; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!seen) begin
         check("done_timeout", 0, 1);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_pass"}, int'(pass_cnt), 0);
      check({tag, "_fail"}, int'(fail_cnt), 0);
      check({tag, "_ffv"}, int'(first_fail_valid), 0);
      check({tag, "_ffvec"}, int'(first_fail_vec), 0);
      check({tag, "_ops"}, int'({a_out, b_out, cin_out}), 0);
   endtask

   task automatic run_sweep(input int fm, input int fb, input int fv);
      fault_mode = fm;
      fault_bit  = fb;
      fault_vec  = fv;
      repeat ($urandom_range(0, 4)) @(negedge clk);
      issue_start();
      wait_done();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_busy", int'(busy), 0);

      run_sweep(0, 0, 0);
      run_sweep(1, 0, 0);
      run_sweep(3, 0, 0);
      // restart from DONE with the same fault: identical totals expected
      issue_start();
      check("restart_clears_pass", int'(pass_cnt), 0);
      check("restart_clears_fail", int'(fail_cnt), 0);
      check("restart_busy", int'(busy), 1);
      wait_done();

      // start while busy must be ignored
      fault_mode = 0;
      issue_start();
      repeat (48) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();

      // reset in the middle of vector 100
      fault_mode = 0;
      issue_start();
      repeat (100*(SETTLE_EFF+1)) @(negedge clk);
      check("vec_before_rst", int'({a_out, b_out, cin_out}), 100);
      check("busy_before_rst", int'(busy), 1);
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      void'(exp_q.pop_back());
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_idle_busy", int'(busy), 0);
      check("post_rst_idle_done", int'(done), 0);
      run_sweep(0, 0, 0);

      for (int k = 0; k < 5; k++)
         run_sweep($urandom_range(0, 4), $urandom_range(0, WIDTH-1), $urandom_range(0, NV-1));

      check("sb_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
